// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR: one shared multiplier walks every tap, one tap per cycle.
// Optional macro FIR_SATURATE_EN clamps the result to the signed DATA_WIDTH range and raises satFlag.
module fir_tap_sequencer #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_SHIFT  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        accelerateEn,
  input  logic                        flush,
  input  logic                        sampleValid,
  output logic                        sampleReady,
  input  logic [DATA_WIDTH-1:0]       sampleIn,
  input  logic                        coefWe,
  input  logic [$clog2(NUM_REGS)-1:0] coefAddr,
  input  logic [DATA_WIDTH-1:0]       coefData,
  output logic                        resultValid,
  input  logic                        resultReady,
  output logic [DATA_WIDTH-1:0]       result,
  output logic                        busy,
  output logic                        satFlag
);
  // state | meaning
  // IDLE  | accept sample, coefficient writes, flush
  // ACCUM | one multiply-accumulate per cycle, newest sample first
  // DONE  | result held until the consumer takes it
  localparam int AW    = $clog2(NUM_REGS);
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int ACC_W = PW + AW;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0]   hist_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   coef_q [NUM_REGS];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q, tap_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [DATA_WIDTH-1:0]   result_q;

  logic                    accept, last_tap;
  logic [DATA_WIDTH-1:0]   coef_sel, hist_sel;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_sum;
  logic [DATA_WIDTH-1:0]   res_d;

  assign accept   = sampleValid && sampleReady;
  assign last_tap = (tap_q == AW'(NUM_REGS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_ACCUM;
      S_ACCUM: if (last_tap) state_d = S_DONE;
      S_DONE:  if (resultReady) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Gating with rst keeps the handshake quiet while reset is held.
  always_comb begin
    sampleReady = 1'b0;
    resultValid = 1'b0;
    busy        = 1'b0;
    case (state_q)
      S_IDLE:  sampleReady = accelerateEn && !flush && rst;
      S_ACCUM: busy = 1'b1;
      S_DONE: begin
        busy        = 1'b1;
        resultValid = 1'b1;
      end
      default: ;
    endcase
  end

  assign coef_sel = coef_q[tap_q];
  assign hist_sel = hist_q[rd_ptr_q];
  assign prod     = $signed({{DATA_WIDTH{coef_sel[DATA_WIDTH-1]}}, coef_sel}) *
                    $signed({{DATA_WIDTH{hist_sel[DATA_WIDTH-1]}}, hist_sel});
  assign acc_sum  = acc_q + $signed({{AW{prod[PW-1]}}, prod});

`ifdef FIR_SATURATE_EN
  logic signed [ACC_W-1:0]   shifted;
  logic [ACC_W-DATA_WIDTH:0] top_bits;
  logic                      sat_d, sat_q;

  assign shifted  = acc_sum >>> OUT_SHIFT;
  assign top_bits = shifted[ACC_W-1:DATA_WIDTH-1];

  // In range only when every bit above the result's sign bit repeats it.
  always_comb begin
    sat_d = 1'b0;
    res_d = shifted[DATA_WIDTH-1:0];
    if (!(&top_bits) && (|top_bits)) begin
      sat_d = 1'b1;
      res_d = shifted[ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                               : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             sat_q <= 1'b0;
    else if (state_q == S_ACCUM && last_tap) sat_q <= sat_d;
  end

  assign satFlag = sat_q;
`else
  assign res_d   = DATA_WIDTH'(acc_sum >>> OUT_SHIFT);
  assign satFlag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tap_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      if (state_q == S_IDLE) begin
        if (coefWe) coef_q[coefAddr] <= coefData;
        if (flush) begin
          for (int i = 0; i < NUM_REGS; i++) hist_q[i] <= '0;
          wr_ptr_q <= '0;
        end else if (accept) begin
          hist_q[wr_ptr_q] <= sampleIn;
          rd_ptr_q         <= wr_ptr_q;
          wr_ptr_q         <= wr_ptr_q + AW'(1);
          tap_q            <= '0;
          acc_q            <= '0;
        end
      end
      if (state_q == S_ACCUM) begin
        acc_q    <= acc_sum;
        tap_q    <= tap_q + AW'(1);
        rd_ptr_q <= rd_ptr_q - AW'(1);
        if (last_tap) result_q <= res_d;
      end
    end
  end

  assign result = result_q;

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
Time-multiplexed FIR controller for the sensor-filter accelerator on the CV32E40X. Accepts one raw sensor sample per valid/ready handshake and keeps a circular sample history plus a coefficient bank. It runs one shared multiplier across all taps, one tap per cycle, and returns the filtered result over a second valid/ready handshake. It replaces the fully parallel shift-register/MAC pair where area matters.

Parameters:
NUM_REGS, 8, number of taps and sample-history depth; power of two, at least 2.
DATA_WIDTH, 32, width of samples, coefficients and result; signed two's complement.
OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before output (Q-format scaling).

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-low reset
accelerateEn  input  1  enables sample acceptance
flush  input  1  clears sample history to zero; honoured in IDLE only
sampleValid  input  1  sample offered
sampleReady  output  1  sequencer can accept a sample
sampleIn  input  DATA_WIDTH  raw sensor sample
coefWe  input  1  coefficient write strobe; honoured in IDLE only
coefAddr  input  $clog2(NUM_REGS)  tap index k
coefData  input  DATA_WIDTH  coefficient c[k]
resultValid  output  1  result available
resultReady  input  1  consumer accepts result
result  output  DATA_WIDTH  filtered output y[n]
busy  output  1  high in ACCUM or DONE
satFlag  output  1  result was clipped (see optional feature)

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; wrPtr=0; all samples and coefficients are 0.
  - sampleReady=0, resultValid=0, result=0, busy=0, satFlag=0.
  - Reset mid-computation discards the computation; no result is emitted.
- Function: y[n] = sum over k=0..NUM_REGS-1 of c[k]*x[n-k]. Unwritten history reads as 0.
- Accumulator: signed, ACC_WIDTH = 2*DATA_WIDTH + $clog2(NUM_REGS) bits, so no internal overflow. Products are full 2*DATA_WIDTH signed values, sign-extended into the accumulator.
- State IDLE:
  - sampleReady = accelerateEn.
  - On sampleValid && sampleReady (cycle T):
    - Write sampleIn to buf[wrPtr].
    - Set rdPtr=wrPtr, tap=0, acc=0.
    - Increment wrPtr, wrapping NUM_REGS-1 to 0.
    - Go to ACCUM.
  - coefWe writes c[coefAddr]=coefData. If coefWe and an accepted sample fall in the same cycle, both take effect; the new coefficient is used by that computation.
  - flush zeroes every buf entry and wrPtr. It takes priority over a simultaneous sample, and sampleReady is 0 that cycle.
- State ACCUM, cycles T+1 .. T+NUM_REGS:
  - Each cycle: acc += c[tap]*buf[rdPtr]; tap++; rdPtr decrements, wrapping 0 to NUM_REGS-1.
  - sampleReady=0. coefWe and flush are ignored.
  - Deasserting accelerateEn does not abort; the computation completes.
  - On the last tap (tap==NUM_REGS-1), register the output into result and go to DONE.
- State DONE:
  - resultValid=1 from cycle T+NUM_REGS+1. result and satFlag are held stable while resultValid && !resultReady.
  - On resultReady, go to IDLE; resultValid drops the next cycle.
  - Earliest next sample acceptance is cycle T+NUM_REGS+2.
- Output formation: s = acc >>> OUT_SHIFT (arithmetic shift); result = s[DATA_WIDTH-1:0] (truncation/wrap) unless the optional feature is enabled.
- busy = (state != IDLE).

Optional Feature:
FIR_SATURATE_EN:
- Defined: if s exceeds the signed DATA_WIDTH range, result clamps to 2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1), and satFlag=1 for that result. Otherwise satFlag=0.
- Undefined: result is truncated (wraps), and satFlag is tied to 0.

Test Plan:
- Impulse: coefs c[k]=k+1, then samples 1,0,0,...,0 (10 samples) -> results 1,2,3,4,5,6,7,8,0,0.
- Latency/backpressure: sample accepted at cycle T with resultReady=0 -> resultValid rises at T+9 (NUM_REGS=8) and result holds 5 cycles. Release resultReady -> resultValid drops the next cycle, and sampleReady rises the cycle after.
- Wrap and history: all c[k]=1, samples 1..12 -> 12th result = 5+6+...+12 = 68. Then assert flush in IDLE and send 3 -> result 3.
- Negative and width: c[0]=-2, x=0x7FFFFFFF, other taps 0, OUT_SHIFT=0 -> undefined: result=0x00000002, satFlag=0. Defined: result=0x80000000, satFlag=1.
- Illegal-time controls: coefWe and flush pulsed during ACCUM -> ignored; result equals the no-pulse value. Deassert accelerateEn mid-ACCUM -> result is still produced, then sampleReady stays 0.
- Reset mid-ACCUM: drive rst=0 at tap 4 -> resultValid never asserts; all outputs are 0. After release, an impulse with c[0]=7 -> result 7.
